// File: rtl/panel_input_conditioner.sv
// ---------------------------------------------------------------------------
// panel_input_conditioner
//
// Front-panel conditioning stage that sits in front of the washing machine
// controller. Raw buttons are synchronized, debounced and turned into
// single-cycle press strobes. Selector inputs are synchronized, checked for
// the invalid code 2'b11 and latched while the machine is idle. A start press
// either fires start_pulse directly or runs a delay-start countdown first.
//
// Ports:
//   clk                     system clock
//   reset                   synchronous, active-high reset
//   power_button_raw        raw power push-button (asynchronous, bouncy)
//   start_button_raw        raw start push-button (asynchronous, bouncy)
//   cycle_select_raw        raw 2-bit cycle selector
//   water_level_select_raw  raw 2-bit water-level selector
//   temp_select_raw         raw 2-bit temperature selector
//   spin_speed_select_raw   raw 2-bit spin-speed selector
//   delay_start_raw         delay-start switch level
//   machine_busy            high while the controller runs a cycle
//   power_pulse             one-cycle pulse per accepted power press
//   start_pulse             one-cycle start request to the controller
//   cycle_select            latched, validated cycle selection
//   water_level_select      latched, validated water level
//   temp_select             latched, validated temperature
//   spin_speed_select       latched, validated spin speed
//   delay_pending           high while the delay-start countdown runs
// ---------------------------------------------------------------------------
module panel_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int DELAY_START_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_button_raw,
    input  logic       start_button_raw,
    input  logic [1:0] cycle_select_raw,
    input  logic [1:0] water_level_select_raw,
    input  logic [1:0] temp_select_raw,
    input  logic [1:0] spin_speed_select_raw,
    input  logic       delay_start_raw,
    input  logic       machine_busy,
    output logic       power_pulse,
    output logic       start_pulse,
    output logic [1:0] cycle_select,
    output logic [1:0] water_level_select,
    output logic [1:0] temp_select,
    output logic [1:0] spin_speed_select,
    output logic       delay_pending
);

    localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] DLY_LOAD = 16'(DELAY_START_TICKS - 1);
    localparam logic [7:0]  SEL_RESET = 8'b01_01_01_01;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        FIRE
    } state_t;

    // Button vectors: bit 0 is power, bit 1 is start.
    logic [1:0]      w_btnRaw;
    logic [1:0]      r_btnS1;
    logic [1:0]      r_btnS2;
    logic [1:0]      r_btnDb;
    logic [1:0]      r_btnRise;
    logic [1:0][7:0] r_btnCnt;

    // Selections packed as {cycle, water, temp, spin}.
    logic [7:0] w_selRaw;
    logic [7:0] r_selS1;
    logic [7:0] r_selS2;
    logic [1:0] r_selValid;
    logic [7:0] r_sel;

    logic r_dlyS1;
    logic r_dlyS2;

    state_t      r_state;
    logic [15:0] r_dcnt;
    logic        r_startPulse;
    logic        r_delayPending;

    assign w_btnRaw = {start_button_raw, power_button_raw};
    assign w_selRaw = {cycle_select_raw, water_level_select_raw,
                       temp_select_raw, spin_speed_select_raw};

    // Button synchronizers and debouncers. A new level is only accepted after
    // the synchronized copy has disagreed with the debounced level for
    // DEBOUNCE_CYCLES consecutive cycles; the rise strobe is raised on the
    // same edge that accepts a new high level, so it lines up with db.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btnS1   <= '0;
            r_btnS2   <= '0;
            r_btnDb   <= '0;
            r_btnRise <= '0;
            r_btnCnt  <= '0;
        end else begin
            r_btnS1 <= w_btnRaw;
            r_btnS2 <= r_btnS1;
            for (int i = 0; i < 2; i++) begin
                r_btnRise[i] <= 1'b0;
                if (r_btnS2[i] == r_btnDb[i]) begin
                    r_btnCnt[i] <= '0;
                end else if (r_btnCnt[i] == DB_LAST) begin
                    r_btnDb[i]   <= r_btnS2[i];
                    r_btnCnt[i]  <= '0;
                    r_btnRise[i] <= r_btnS2[i];
                end else begin
                    r_btnCnt[i] <= r_btnCnt[i] + 8'd1;
                end
            end
        end
    end

    // Selection synchronizer and latch. r_selValid tracks whether real input
    // data has reached the second flop since reset, so the cleared flop
    // contents are never mistaken for a user selection of 2'b00.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_selS1    <= '0;
            r_selS2    <= '0;
            r_selValid <= '0;
            r_sel      <= SEL_RESET;
            r_dlyS1    <= 1'b0;
            r_dlyS2    <= 1'b0;
        end else begin
            r_selS1    <= w_selRaw;
            r_selS2    <= r_selS1;
            r_selValid <= {r_selValid[0], 1'b1};
            r_dlyS1    <= delay_start_raw;
            r_dlyS2    <= r_dlyS1;
            if (!machine_busy && r_selValid[1]) begin
                for (int i = 0; i < 4; i++) begin
                    if (r_selS2[2*i +: 2] != 2'b11) begin
                        r_sel[2*i +: 2] <= r_selS2[2*i +: 2];
                    end
                end
            end
        end
    end

    // Start FSM. start_pulse and delay_pending are set on the edge that enters
    // FIRE / DELAY, so FIRE lasts exactly the one cycle the pulse is high.
    // In DELAY a cancel (either button press or busy) wins over expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_dcnt         <= '0;
            r_startPulse   <= 1'b0;
            r_delayPending <= 1'b0;
        end else begin
            r_startPulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_btnRise[1] && !machine_busy) begin
                        if (r_dlyS2) begin
                            r_state        <= DELAY;
                            r_dcnt         <= DLY_LOAD;
                            r_delayPending <= 1'b1;
                        end else begin
                            r_state      <= FIRE;
                            r_startPulse <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (r_btnRise[1] || r_btnRise[0] || machine_busy) begin
                        r_state        <= IDLE;
                        r_delayPending <= 1'b0;
                    end else if (r_dcnt == 16'd0) begin
                        r_state        <= FIRE;
                        r_delayPending <= 1'b0;
                        r_startPulse   <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt - 16'd1;
                    end
                end
                FIRE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state        <= IDLE;
                    r_delayPending <= 1'b0;
                end
            endcase
        end
    end

    assign power_pulse        = r_btnRise[0];
    assign start_pulse        = r_startPulse;
    assign delay_pending      = r_delayPending;
    assign cycle_select       = r_sel[7:6];
    assign water_level_select = r_sel[5:4];
    assign temp_select        = r_sel[3:2];
    assign spin_speed_select  = r_sel[1:0];

endmodule
